register_file: RTL and testbench

- MIPS general-purpose register file: 2^AddrWidth entries of DataWidth bits.
- Reading side of the datapath storage: the decode stage reads rs/rt operands here; the writeback stage writes rd/rt results.
- Two combinational read ports and one synchronous write port; entry 0 is hardwired to zero per MIPS $zero.

---
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: MIPS general-purpose register file.
// 2^AddrWidth entries of DataWidth bits, two combinational read ports and
// one synchronous write port. Entry 0 is hardwired to zero ($zero).
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write in
// flight is forwarded to matching read ports in the same cycle.
module register_file #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [AddrWidth-1:0] RDAddr1,
    output logic [DataWidth-1:0] RDData1,
    input  logic [AddrWidth-1:0] RDAddr2,
    output logic [DataWidth-1:0] RDData2,
    input  logic [AddrWidth-1:0] WRAddr,
    input  logic [DataWidth-1:0] WRData,
    input  logic                 WREnable
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [DataWidth-1:0] regs_q [Depth];
    logic [Depth-1:0]     wr_sel_d;
    logic                 wr_valid;

    // The explicit ==1'b1 compare keeps an unknown strobe from writing.
    assign wr_valid = (WREnable == 1'b1) && (WRAddr != '0);

    // Per-entry write select; entry 0 is never selected.
    always_comb begin
        wr_sel_d = '0;
        for (int unsigned i = 1; i < Depth; i++) begin
            wr_sel_d[i] = wr_valid && (WRAddr == AddrWidth'(i));
        end
    end

    // Storage: asynchronous clear on reset, otherwise write the selected entry.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < Depth; i++) begin
                if (wr_sel_d[i]) begin
                    regs_q[i] <= WRData;
                end
            end
        end
    end

    // Read port 1: zero for $zero or during reset, else stored (or forwarded) data.
    always_comb begin
        RDData1 = '0;
        if (RST == 1'b1 && RDAddr1 != '0) begin
            RDData1 = regs_q[RDAddr1];
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && RDAddr1 == WRAddr) begin
                RDData1 = WRData;
            end
`endif
        end
    end

    // Read port 2: same rules as port 1, fully independent.
    always_comb begin
        RDData2 = '0;
        if (RST == 1'b1 && RDAddr2 != '0) begin
            RDData2 = regs_q[RDAddr2];
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && RDAddr2 == WRAddr) begin
                RDData2 = WRData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file with a
// behavioural array model of the 32 x 32-bit register file.
module tb_register_file;

    logic        clk;
    logic        RST;
    logic [4:0]  RDAddr1;
    logic [31:0] RDData1;
    logic [4:0]  RDAddr2;
    logic [31:0] RDData2;
    logic [4:0]  WRAddr;
    logic [31:0] WRData;
    logic        WREnable;

    logic [31:0] model [32];
    int vectors;
    int errors;

    register_file #(
        .DataWidth(32),
        .AddrWidth(5)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .RDAddr1 (RDAddr1),
        .RDData1 (RDData1),
        .RDAddr2 (RDAddr2),
        .RDData2 (RDData2),
        .WRAddr  (WRAddr),
        .WRData  (WRData),
        .WREnable(WREnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, update the model, land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        if (RST === 1'b1 && WREnable === 1'b1 && WRAddr != 5'd0)
            model[WRAddr] = WRData;
        #1;
    endtask

    // Expected combinational read value for address a under current inputs.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        logic [31:0] v;
        if (RST !== 1'b1 || a == 5'd0) return 32'h0;
        v = model[a];
`ifdef REGFILE_BYPASS_EN
        if (WREnable === 1'b1 && WRAddr != 5'd0 && a == WRAddr) v = WRData;
`endif
        return v;
    endfunction

    task automatic test_reset();
        logic [31:0] e;
        // Reset state
        #1;
        RDAddr1 = 5'd3; RDAddr2 = 5'd31; #1;
        vectors++;
        if (RDData1 !== 32'h0 || RDData2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rd1=%h rd2=%h required 0 0", RDData1, RDData2);
        end
        @(posedge clk); #1;
        RST = 1'b1;
        // Fill 1..31 with all ones
        for (int a = 1; a < 32; a++) begin
            WRAddr = 5'(a); WRData = 32'hFFFF_FFFF; WREnable = 1'b1;
            tick();
        end
        WREnable = 1'b0;
        RDAddr1 = 5'd5; RDAddr2 = 5'd31; #1;
        vectors++;
        if (RDData1 !== 32'hFFFF_FFFF || RDData2 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_preload: rd1=%h rd2=%h required ffffffff ffffffff", RDData1, RDData2);
        end
        // Assert reset mid-cycle; clearing must be visible before the next edge
        #2;
        RST = 1'b0;
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        #1;
        vectors++;
        if (RDData1 !== 32'h0 || RDData2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: rd1=%h rd2=%h required 0 0", RDData1, RDData2);
        end
        // A write attempted while in reset is ignored
        WRAddr = 5'd5; WRData = 32'h1234_5678; WREnable = 1'b1;
        tick();
        WREnable = 1'b0;
        RST = 1'b1;
        for (int a = 0; a < 32; a++) begin
            RDAddr1 = 5'(a); RDAddr2 = 5'(31 - a); #1;
            e = 32'h0;
            vectors++;
            if (RDData1 !== e || RDData2 !== e) begin
                errors++;
                $display("FAIL reset_clear a=%0d: rd1=%h rd2=%h required 0 0", a, RDData1, RDData2);
            end
        end
    endtask

    task automatic test_basic();
        WRAddr = 5'd5;  WRData = 32'h1234_5678; WREnable = 1'b1; tick();
        WRAddr = 5'd31; WRData = 32'hDEAD_BEEF; tick();
        WREnable = 1'b0;
        RDAddr1 = 5'd5; RDAddr2 = 5'd31; #1;
        vectors++;
        if (RDData1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL basic_rd1: got %h required 12345678", RDData1);
        end
        vectors++;
        if (RDData2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_rd2: got %h required deadbeef", RDData2);
        end
    endtask

    task automatic test_zero();
        WRAddr = 5'd0; WRData = 32'hA5A5_A5A5; WREnable = 1'b1;
        RDAddr1 = 5'd0; RDAddr2 = 5'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (RDData1 !== 32'h0 || RDData2 !== 32'h0) begin
                errors++;
                $display("FAIL zero_reg c=%0d: rd1=%h rd2=%h required 0 0", c, RDData1, RDData2);
            end
        end
        WREnable = 1'b0;
    endtask

    task automatic test_enable();
        WRAddr = 5'd7; WRData = 32'h0000_0011; WREnable = 1'b1; tick();
        WRData = 32'h2222_2222; WREnable = 1'b0;
        RDAddr1 = 5'd7; RDAddr2 = 5'd7;
        for (int c = 0; c < 3; c++) tick();
        vectors++;
        if (RDData1 !== 32'h0000_0011 || RDData2 !== 32'h0000_0011) begin
            errors++;
            $display("FAIL enable_gate: rd1=%h rd2=%h required 00000011", RDData1, RDData2);
        end
        // Unknown strobe must not write either
        WREnable = 1'bx; WRData = 32'h3333_3333;
        tick();
        WREnable = 1'b0; #1;
        vectors++;
        if (RDData1 !== 32'h0000_0011) begin
            errors++;
            $display("FAIL enable_x: got %h required 00000011", RDData1);
        end
    endtask

    task automatic test_collision();
        logic [31:0] pre;
        WRAddr = 5'd9; WRData = 32'h1; WREnable = 1'b1; tick();
        WRData = 32'h9; RDAddr1 = 5'd9; RDAddr2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        pre = 32'h9;
`else
        pre = 32'h1;
`endif
        vectors++;
        if (RDData1 !== pre || RDData2 !== pre) begin
            errors++;
            $display("FAIL collision_pre: rd1=%h rd2=%h required %h", RDData1, RDData2, pre);
        end
        tick();
        WREnable = 1'b0; #1;
        vectors++;
        if (RDData1 !== 32'h9 || RDData2 !== 32'h9) begin
            errors++;
            $display("FAIL collision_post: rd1=%h rd2=%h required 00000009", RDData1, RDData2);
        end
    endtask

    task automatic test_walk();
        logic [31:0] e1, e2;
        int bad;
        for (int a = 0; a < 32; a++) begin
            WRAddr = 5'(a); WRData = 32'(a) * 32'h0101_0101; WREnable = 1'b1;
            tick();
        end
        WREnable = 1'b0;
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                RDAddr1 = 5'(a); RDAddr2 = 5'(b); #1;
                e1 = (a == 0) ? 32'h0 : 32'(a) * 32'h0101_0101;
                e2 = (b == 0) ? 32'h0 : 32'(b) * 32'h0101_0101;
                vectors++;
                if ((RDData1 !== e1 || RDData2 !== e2) && bad < 8) begin
                    errors++; bad++;
                    $display("FAIL walk a=%0d b=%0d: rd1=%h rd2=%h required %h %h", a, b, RDData1, RDData2, e1, e2);
                end else if (RDData1 !== e1 || RDData2 !== e2) begin
                    errors++;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int c = 0; c < 300; c++) begin
            WREnable = 1'($urandom_range(0, 1));
            WRAddr   = 5'($urandom);
            WRData   = $urandom;
            RDAddr1  = ($urandom_range(0, 3) == 0) ? WRAddr : 5'($urandom);
            RDAddr2  = ($urandom_range(0, 3) == 0) ? WRAddr : 5'($urandom);
            #1;
            e1 = expect_rd(RDAddr1);
            e2 = expect_rd(RDAddr2);
            vectors++;
            if (RDData1 !== e1 || RDData2 !== e2) begin
                errors++;
                $display("FAIL random c=%0d ra1=%0d ra2=%0d: rd1=%h rd2=%h required %h %h",
                         c, RDAddr1, RDAddr2, RDData1, RDData2, e1, e2);
            end
            tick();
        end
        WREnable = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RST = 1'b0; WREnable = 1'b0; WRAddr = '0; WRData = '0;
        RDAddr1 = '0; RDAddr2 = '0;
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        test_reset();
        test_basic();
        test_zero();
        test_enable();
        test_collision();
        test_walk();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
